// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the multicycle MIPS controller, the ALU
// and the datapath.
//   state_t      - controller FSM states
//   OP_* / FN_*  - opcode and R-type funct field encodings
//   ALU_*        - 3-bit alu_control encodings
//   CAUSE_*      - exc_cause encodings
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC,
    S_ALUWB,
    S_BRANCH,
    S_ADDIEX,
    S_ADDIWB,
    S_JUMP,
    S_EXC
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic CAUSE_OVERFLOW = 1'b0;
  localparam logic CAUSE_ILLEGAL  = 1'b1;

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// mips_mc_ctrl_if: bundle between the multicycle controller and the datapath.
//   Datapath -> controller: op, funct, zero, of, mem_ready
//   Controller -> datapath: mux selects, write strobes, alu_control,
//                           exc / exc_cause
//   modport master: the controller; modport slave: the datapath side.
interface mips_mc_ctrl_if;

  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       of;
  logic       mem_ready;

  logic       iord;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic       pc_en;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic [2:0] alu_control;
  logic       exc;
  logic       exc_cause;

  modport master (
    input  op, funct, zero, of, mem_ready,
    output iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, pc_en, alu_src_b, pc_src, alu_control, exc, exc_cause
  );

  modport slave (
    output op, funct, zero, of, mem_ready,
    input  iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, pc_en, alu_src_b, pc_src, alu_control, exc, exc_cause
  );

endinterface

// File: rtl/alu_dec.sv
// alu_dec: combinational R-type funct decoder.
//   funct       in  6  R-type funct field
//   alu_control out 3  ALU operation (AND when the funct is illegal)
//   illegal     out 1  funct is not one of ADD/SUB/AND/OR/SLT
//   addsub      out 1  funct is ADD or SUB (the only overflow-checked ops)
module alu_dec
  import mips_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       illegal,
  output logic       addsub
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a variable unassigned, which would infer a latch.
    alu_control = ALU_AND;
    illegal     = 1'b0;
    addsub      = 1'b0;
    unique case (funct)
      FN_ADD: begin alu_control = ALU_ADD; addsub = 1'b1; end
      FN_SUB: begin alu_control = ALU_SUB; addsub = 1'b1; end
      FN_AND: alu_control = ALU_AND;
      FN_OR:  alu_control = ALU_OR;
      FN_SLT: alu_control = ALU_SLT;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: Moore-style control FSM for a multicycle MIPS datapath.
//   clk   in  single clock, rising edge
//   rst_n in  asynchronous active-low reset
//   bus   mips_mc_ctrl_if.master: instruction fields, ALU flags and memory
//         handshake in; datapath selects, strobes, alu_control and the
//         exception report out.
// The only input-dependent outputs are ir_write/pc_en in FETCH (follow
// mem_ready) and pc_en in BRANCH (follows zero). Write strobes are also
// gated by rst_n directly so they fall the instant reset asserts.
module mips_mc_ctrl
  import mips_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  mips_mc_ctrl_if.master bus
);

  state_t state_q, state_d;
  logic   cause_q, cause_d;

  logic [2:0] fn_alu;
  logic       fn_illegal;
  logic       fn_addsub;

  alu_dec u_alu_dec (
    .funct       (bus.funct),
    .alu_control (fn_alu),
    .illegal     (fn_illegal),
    .addsub      (fn_addsub)
  );

  // The cause is captured on entry to EXC and only presented while in EXC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: state updates use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state_q <= S_FETCH;
      cause_q <= CAUSE_OVERFLOW;
    end else begin
      state_q <= state_d;
      if (state_d == S_EXC) cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cause_d         = CAUSE_OVERFLOW;
    bus.iord        = 1'b0;
    bus.mem_write   = 1'b0;
    bus.ir_write    = 1'b0;
    bus.reg_dst     = 1'b0;
    bus.mem_to_reg  = 1'b0;
    bus.reg_write   = 1'b0;
    bus.alu_src_a   = 1'b0;
    bus.pc_en       = 1'b0;
    bus.alu_src_b   = 2'b00;
    bus.pc_src      = 2'b00;
    bus.alu_control = ALU_AND;
    bus.exc         = 1'b0;
    bus.exc_cause   = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        bus.alu_src_b   = 2'b01;
        bus.alu_control = ALU_ADD;
        bus.ir_write    = bus.mem_ready;
        bus.pc_en       = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // ALU precomputes the branch target while the opcode is decoded.
        bus.alu_src_b   = 2'b11;
        bus.alu_control = ALU_ADD;
        unique case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d = S_EXC;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEMADR: begin
        bus.alu_src_a   = 1'b1;
        bus.alu_src_b   = 2'b10;
        bus.alu_control = ALU_ADD;
        state_d = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        bus.iord = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        bus.mem_to_reg = 1'b1;
        bus.reg_write  = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMWR: begin
        bus.iord      = 1'b1;
        bus.mem_write = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
      end
      S_EXEC: begin
        bus.alu_src_a   = 1'b1;
        bus.alu_control = fn_alu;
        if (fn_illegal) begin
          state_d = S_EXC;
          cause_d = CAUSE_ILLEGAL;
        end else if (fn_addsub && bus.of) begin
          state_d = S_EXC;
          cause_d = CAUSE_OVERFLOW;
        end else begin
          state_d = S_ALUWB;
        end
      end
      S_ALUWB: begin
        bus.reg_dst   = 1'b1;
        bus.reg_write = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        bus.alu_src_a   = 1'b1;
        bus.alu_control = ALU_SUB;
        bus.pc_src      = 2'b01;
        bus.pc_en       = bus.zero;
        state_d = S_FETCH;
      end
      S_ADDIEX: begin
        bus.alu_src_a   = 1'b1;
        bus.alu_src_b   = 2'b10;
        bus.alu_control = ALU_ADD;
        if (bus.of) begin
          state_d = S_EXC;
          cause_d = CAUSE_OVERFLOW;
        end else begin
          state_d = S_ADDIWB;
        end
      end
      S_ADDIWB: begin
        bus.reg_write = 1'b1;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        bus.pc_src = 2'b10;
        bus.pc_en  = 1'b1;
        state_d = S_FETCH;
      end
      S_EXC: begin
        bus.exc       = 1'b1;
        bus.exc_cause = cause_q;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Asynchronous kill of every write strobe while reset is asserted.
    if (!rst_n) begin
      bus.ir_write  = 1'b0;
      bus.pc_en     = 1'b0;
      bus.reg_write = 1'b0;
      bus.mem_write = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb_mips_mc_ctrl: self-checking bench for mips_mc_ctrl. An instruction-level
// model expands each instruction into the expected per-cycle output vectors
// (plus the mem_ready/of/zero values to drive), and the run loop applies them
// and compares every cycle.
module tb_mips_mc_ctrl;

  localparam logic [2:0] A_AND = 3'b000, A_OR = 3'b001, A_ADD = 3'b010,
                         A_SUB = 3'b110, A_SLT = 3'b111;

  typedef struct packed {
    logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                alu_src_a, pc_en;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;
    logic       exc, exc_cause;
  } outs_t;

  typedef struct {
    string tag;
    logic  mr, ofv, zv;
    outs_t exp;
  } cyc_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  cyc_t plan[$];

  mips_mc_ctrl_if bus ();

  mips_mc_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic outs_t sample();
    outs_t o;
    o.iord = bus.iord;           o.mem_write = bus.mem_write;
    o.ir_write = bus.ir_write;   o.reg_dst = bus.reg_dst;
    o.mem_to_reg = bus.mem_to_reg; o.reg_write = bus.reg_write;
    o.alu_src_a = bus.alu_src_a; o.pc_en = bus.pc_en;
    o.alu_src_b = bus.alu_src_b; o.pc_src = bus.pc_src;
    o.alu_control = bus.alu_control;
    o.exc = bus.exc;             o.exc_cause = bus.exc_cause;
    return o;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(1, 0));
  endfunction

  task automatic push(input string tag, input logic mr, input logic ofv,
                      input logic zv, input outs_t exp);
    cyc_t c;
    c.tag = tag; c.mr = mr; c.ofv = ofv; c.zv = zv; c.exp = exp;
    plan.push_back(c);
  endtask

  function automatic outs_t fetch_vec(input logic ready);
    outs_t o = '0;
    o.alu_src_b = 2'b01; o.alu_control = A_ADD;
    o.ir_write = ready;  o.pc_en = ready;
    return o;
  endfunction

  function automatic outs_t exc_vec(input logic cause);
    outs_t o = '0;
    o.exc = 1'b1; o.exc_cause = cause;
    return o;
  endfunction

  // Expand one instruction into its expected cycle sequence.
  task automatic plan_instr(input logic [5:0] op, input logic [5:0] funct,
                            input logic of_i, input logic zero_i,
                            input int fetch_wait, input int mem_wait);
    outs_t o;
    logic  legal;
    logic  chk_of;
    logic [2:0] alu;
    for (int i = 0; i < fetch_wait; i++)
      push("fetch_wait", 1'b0, rb(), rb(), fetch_vec(1'b0));
    push("fetch", 1'b1, rb(), rb(), fetch_vec(1'b1));
    o = '0; o.alu_src_b = 2'b11; o.alu_control = A_ADD;
    push("decode", rb(), rb(), rb(), o);
    case (op)
      6'b100011, 6'b101011: begin
        o = '0; o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_control = A_ADD;
        push("memadr", rb(), rb(), rb(), o);
        o = '0; o.iord = 1'b1; o.mem_write = (op == 6'b101011);
        for (int i = 0; i < mem_wait; i++)
          push(op == 6'b101011 ? "memwr_wait" : "memrd_wait", 1'b0, rb(), rb(), o);
        push(op == 6'b101011 ? "memwr" : "memrd", 1'b1, rb(), rb(), o);
        if (op == 6'b100011) begin
          o = '0; o.mem_to_reg = 1'b1; o.reg_write = 1'b1;
          push("memwb", rb(), rb(), rb(), o);
        end
      end
      6'b000000: begin
        legal = 1'b1; chk_of = 1'b0; alu = A_AND;
        case (funct)
          6'b100000: begin alu = A_ADD; chk_of = 1'b1; end
          6'b100010: begin alu = A_SUB; chk_of = 1'b1; end
          6'b100100: alu = A_AND;
          6'b100101: alu = A_OR;
          6'b101010: alu = A_SLT;
          default:   legal = 1'b0;
        endcase
        o = '0; o.alu_src_a = 1'b1; o.alu_control = alu;
        push("exec", rb(), of_i, rb(), o);
        if (!legal) push("exc_illegal_fn", rb(), rb(), rb(), exc_vec(1'b1));
        else if (chk_of && of_i) push("exc_of", rb(), rb(), rb(), exc_vec(1'b0));
        else begin
          o = '0; o.reg_dst = 1'b1; o.reg_write = 1'b1;
          push("aluwb", rb(), rb(), rb(), o);
        end
      end
      6'b000100: begin
        o = '0; o.alu_src_a = 1'b1; o.alu_control = A_SUB;
        o.pc_src = 2'b01; o.pc_en = zero_i;
        push("branch", rb(), rb(), zero_i, o);
      end
      6'b001000: begin
        o = '0; o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_control = A_ADD;
        push("addiex", rb(), of_i, rb(), o);
        if (of_i) push("exc_addi_of", rb(), rb(), rb(), exc_vec(1'b0));
        else begin
          o = '0; o.reg_write = 1'b1;
          push("addiwb", rb(), rb(), rb(), o);
        end
      end
      6'b000010: begin
        o = '0; o.pc_src = 2'b10; o.pc_en = 1'b1;
        push("jump", rb(), rb(), rb(), o);
      end
      default: push("exc_illegal_op", rb(), rb(), rb(), exc_vec(1'b1));
    endcase
  endtask

  // Apply one planned cycle: drive at negedge, compare 1 time unit later.
  task automatic step(input cyc_t c);
    @(negedge clk);
    bus.mem_ready = c.mr; bus.of = c.ofv; bus.zero = c.zv;
    #1;
    check(c.tag, 32'(sample()), 32'(c.exp));
  endtask

  task automatic run_plan();
    while (plan.size() > 0) step(plan.pop_front());
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] funct,
                           input logic of_i, input logic zero_i,
                           input int fw, input int mw);
    bus.op = op; bus.funct = funct;
    plan_instr(op, funct, of_i, zero_i, fw, mw);
    run_plan();
  endtask

  outs_t rst_vec;
  logic [5:0] ops [6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                          6'b001000, 6'b000010};
  logic [5:0] fns [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                          6'b101010};

  initial begin
    logic [5:0] op, fn;
    cyc_t c;
    bus.op = '0; bus.funct = '0; bus.zero = 1'b0; bus.of = 1'b0;
    bus.mem_ready = 1'b1;
    rst_vec = fetch_vec(1'b0);

    // Reset held with mem_ready high: FETCH outputs but no strobes.
    #12;
    check("reset_state", 32'(sample()), 32'(rst_vec));
    @(negedge clk);
    check("reset_hold", 32'(sample()), 32'(rst_vec));
    bus.mem_ready = 1'b0;
    rst_n = 1'b1;

    // Directed scenarios.
    run_instr(6'b000000, 6'b100000, 1'b0, 1'b0, 0, 0); // add
    run_instr(6'b100011, 6'b000000, 1'b0, 1'b0, 1, 3); // lw, 3 wait cycles
    run_instr(6'b000100, 6'b000000, 1'b0, 1'b1, 0, 0); // beq taken
    run_instr(6'b000100, 6'b000000, 1'b0, 1'b0, 0, 0); // beq not taken
    run_instr(6'b000000, 6'b100010, 1'b1, 1'b0, 0, 0); // sub overflow
    run_instr(6'b000000, 6'b100100, 1'b1, 1'b0, 0, 0); // and, of ignored
    run_instr(6'b111111, 6'b000000, 1'b0, 1'b0, 0, 0); // illegal opcode
    run_instr(6'b000000, 6'b111111, 1'b0, 1'b0, 0, 0); // illegal funct
    run_instr(6'b001000, 6'b000000, 1'b1, 1'b0, 0, 0); // addi overflow
    run_instr(6'b001000, 6'b000000, 1'b0, 1'b0, 0, 0); // addi
    run_instr(6'b101011, 6'b000000, 1'b0, 1'b0, 2, 2); // sw
    run_instr(6'b000010, 6'b000000, 1'b1, 1'b1, 0, 0); // j

    // Randomized instruction stream.
    for (int n = 0; n < 300; n++) begin
      op = ($urandom_range(7, 0) == 0) ? 6'($urandom) : ops[$urandom_range(5, 0)];
      fn = ($urandom_range(5, 0) == 0) ? 6'($urandom) : fns[$urandom_range(4, 0)];
      run_instr(op, fn, rb(), rb(), $urandom_range(2, 0), $urandom_range(4, 0));
    end

    // Reset pulsed in the middle of a MEMWR wait.
    bus.op = 6'b101011; bus.funct = '0;
    plan_instr(6'b101011, 6'b000000, 1'b0, 1'b0, 0, 5);
    do begin
      c = plan.pop_front();
      step(c);
    end while (c.tag != "memwr_wait" && plan.size() > 0);
    check("memwr_reached", 32'(c.tag == "memwr_wait"), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_mem_write", 32'(bus.mem_write), 32'd0);
    check("rst_async_state", 32'(sample()), 32'(rst_vec));
    plan.delete();
    bus.mem_ready = 1'b0;
    @(negedge clk);
    check("rst_hold_fetch", 32'(sample()), 32'(rst_vec));
    rst_n = 1'b1;
    run_instr(6'b000000, 6'b100101, 1'b0, 1'b0, 1, 0); // or, from FETCH

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_mc_ctrl.md
MIPS_MC_CTRL -- requirements
Module: mips_mc_ctrl

Interface
REQ-001 SHALL have ports, clock and reset first: clk  input  1  single clock, all state changes on the rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 op  input  6  opcode field from the instruction register.
REQ-004 funct  input  6  R-type funct field.
REQ-005 zero  input  1  zero flag from the datapath ALU.
REQ-006 of  input  1  overflow flag from the datapath ALU.
REQ-007 mem_ready  input  1  memory handshake; the current memory access completes on the cycle it is high.
REQ-008 Outputs, all 1 bit unless stated: iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, pc_en; alu_src_b (2), pc_src (2), alu_control (3), exc, exc_cause (0 = overflow, 1 = illegal opcode).

Function
REQ-009 SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, EXC.
REQ-010 ALU encoding SHALL be: AND 000, OR 001, ADD 010, SUB 110, SLT 111.
REQ-011 Decoded opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
REQ-012 R-type funct decode: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT; any other funct treated as illegal.
REQ-013 FETCH: iord=0, alu_src_a=0, alu_src_b=01, alu_control=ADD, pc_src=00; ir_write and pc_en equal mem_ready; hold in FETCH until mem_ready=1, then go to DECODE.
REQ-014 DECODE: alu_src_a=0, alu_src_b=11, alu_control=ADD (branch target); next state chosen by op: lw/sw->MEMADR, R->EXEC, beq->BRANCH, addi->ADDIEX, j->JUMP, other->EXC with exc_cause=1.
REQ-015 MEMADR: alu_src_a=1, alu_src_b=10, ADD; lw->MEMRD, sw->MEMWR.
REQ-016 MEMRD: iord=1; hold until mem_ready=1, then go to MEMWB. MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1, then FETCH.
REQ-017 MEMWR: iord=1, mem_write=1; hold until mem_ready=1, then go to FETCH.
REQ-018 EXEC: alu_src_a=1, alu_src_b=00, alu_control per funct; if the funct is ADD or SUB and of=1 -> EXC with exc_cause=0; else -> ALUWB. An illegal funct goes to EXC with exc_cause=1.
REQ-019 ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1, then FETCH.
REQ-020 BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_src=01, pc_en=zero, then FETCH.
REQ-021 ADDIEX: alu_src_a=1, alu_src_b=10, ADD; of=1 -> EXC with exc_cause=0, else ADDIWB. ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1, then FETCH.
REQ-022 JUMP: pc_src=10, pc_en=1, then FETCH.
REQ-023 EXC: exc=1 for exactly one cycle; reg_write, mem_write and pc_en are 0; exc_cause holds the registered cause; then FETCH.
REQ-024 Any output not listed for a state SHALL be 0; of is ignored in every state other than EXEC (ADD/SUB only) and ADDIEX.
REQ-025 Wait states (FETCH, MEMRD, MEMWR) with mem_ready=0 SHALL hold every output steady and produce no write strobe other than the state's own.

Reset
REQ-026 While rst_n=0, the state SHALL be FETCH, exc_cause 0, and every write enable (ir_write, pc_en, reg_write, mem_write) forced to 0.
REQ-027 Reset assertion mid-instruction SHALL abort immediately with no partial write; the first fetch occurs on the first rising edge with rst_n=1 and mem_ready=1.

Structure
REQ-028 Shared package mips_pkg SHALL hold: the state enum, the opcode/funct localparams, and the ALU control encodings (also used by the ALU and datapath).
REQ-029 One sub-module SHALL be used: alu_dec (combinational funct-to-alu_control and illegal-funct decode); the FSM stays in mips_mc_ctrl.

Verification
REQ-030 add: op=000000, funct=100000, of=0, mem_ready=1 -> FETCH, DECODE, EXEC (alu_control=010), ALUWB (reg_write=1, reg_dst=1), FETCH; 4 cycles.
REQ-031 lw with mem_ready low for 3 cycles in MEMRD -> iord=1 held 4 cycles, then MEMWB with mem_to_reg=1 and reg_write=1.
REQ-032 beq: zero=1 -> pc_en=1 and pc_src=01 in BRANCH; with zero=0 -> pc_en=0 in BRANCH.
REQ-033 sub with of=1 in EXEC -> EXC, exc=1, exc_cause=0, no reg_write; the same sequence with AND funct and of=1 -> ALUWB, no exc.
REQ-034 op=111111 -> DECODE to EXC with exc_cause=1, then FETCH; rst_n pulsed low during MEMWR -> mem_write drops asynchronously and the state is FETCH.
